// File: rtl/uart_pkg.sv
// Shared definitions for the 7E1 UART transmit path: word/frame sizes and TX FSM states.
package uart_pkg;

  localparam int DATA_W           = 7;
  localparam int FRAME_BITS       = 10;
  localparam int DEF_CLKS_PER_BIT = 1736;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    GUARD
  } tx_state_t;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_W-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Round-robin picker: first asserted req searching rr_ptr, rr_ptr+1, ... mod N_REQ.
module uart_rr_picker
  import uart_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       rr_ptr,
  output logic             any,
  output logic [2:0]       winner
);

  logic [2*N_REQ-1:0] req2;
  logic [N_REQ-1:0]   req_rot;
  logic [3:0]         sum;
  logic               found;

  // Rotate so bit 0 of req_rot is requester rr_ptr, then take the lowest set bit.
  always_comb begin
    req2    = {req, req} >> rr_ptr;
    req_rot = req2[N_REQ-1:0];
    found   = 1'b0;
    sum     = 4'd0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, rr_ptr} + 4'(k);
      end
    end
    if (sum >= 4'(N_REQ)) sum = sum - 4'(N_REQ);
    any    = found;
    winner = sum[2:0];
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin shared UART transmitter: start, 7 data bits LSB first, even parity, stop, guard.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int GUARD_BITS   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [DATA_W*N_REQ-1:0] data_in,
  output logic [N_REQ-1:0]        ack,
  output logic [2:0]              owner,
  output logic                    busy,
  output logic                    tx
);

  localparam int                CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        DATA_LAST  = 3'(DATA_W - 1);
  localparam logic [2:0]        GUARD_LAST = (GUARD_BITS > 0) ? 3'(GUARD_BITS - 1) : 3'd0;

  tx_state_t         state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] shift_reg;
  logic              parity;
  logic [2:0]        rr_ptr;
  logic              pick_any;
  logic [2:0]        pick_winner;
  logic [DATA_W-1:0] sel_word;
  logic              bit_done;

  uart_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr),
    .any    (pick_any),
    .winner (pick_winner)
  );

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (3'(i) == pick_winner) sel_word = data_in[DATA_W*i +: DATA_W];
    end
  end

  assign bit_done = (cnt == CNT_LAST);

  // State register plus the datapath that advances with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      parity    <= 1'b0;
      rr_ptr    <= '0;
      owner     <= '0;
      ack       <= '0;
    end else begin
      state <= state_next;
      ack   <= '0;
      if (state == IDLE) begin
        cnt     <= '0;
        bit_idx <= '0;
        if (pick_any) begin
          shift_reg <= sel_word;
          parity    <= even_parity(sel_word);
          ack       <= N_REQ'(1) << pick_winner;
          owner     <= pick_winner;
          rr_ptr    <= (pick_winner == 3'(N_REQ - 1)) ? 3'd0 : pick_winner + 3'd1;
        end
      end else if (bit_done) begin
        cnt     <= '0;
        // bit_idx counts data bits in DATA and guard bit times in GUARD.
        bit_idx <= (state_next != state) ? 3'd0 : bit_idx + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_any) state_next = START;
      START:   if (bit_done) state_next = DATA;
      DATA:    if (bit_done && bit_idx == DATA_LAST) state_next = PARITY;
      PARITY:  if (bit_done) state_next = STOP;
      STOP:    if (bit_done) state_next = (GUARD_BITS == 0) ? IDLE : GUARD;
      GUARD:   if (bit_done && bit_idx == GUARD_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx   = 1'b1;
    busy = (state != IDLE);
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shift_reg[bit_idx];
      PARITY:  tx = parity;
      default: tx = 1'b1;
    endcase
  end

endmodule
